apb_cmd_requester: RTL and testbench
====================================

APB_CMD_REQUESTER -- requirements
Module: apb_cmd_requester

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 - ADDR_WIDTH, 32, paddr/cmd_addr width.
 - DATA_WIDTH, 32, data width; multiple of 8.
 - CMD_DEPTH, 4, command FIFO entries; power of 2, >=2.
 - TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-002 Ports (name, direction, width, meaning), one per line:
 - pclk  in  1  clock
 - preset_n  in  1  reset
 - cmd_valid  in  1  command offered
 - cmd_ready  out  1  command FIFO not full
 - cmd_write  in  1  1=write, 0=read
 - cmd_addr  in  ADDR_WIDTH  target address
 - cmd_wdata  in  DATA_WIDTH  write data
 - cmd_strb  in  DATA_WIDTH/8  write strobes
 - cmd_prot  in  3  pprot value
 - cmd_nse  in  1  pnse value
 - rsp_valid  out  1  response held
 - rsp_ready  in  1  response consumed
 - rsp_rdata  out  DATA_WIDTH  read data
 - rsp_slverr  out  1  error
 - rsp_timeout  out  1  transfer aborted on timeout
 - paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb, pwakeup  out  APB widths  APB requester outputs
 - pready, prdata, pslverr  in  APB widths  completer inputs
REQ-003 One clock, pclk; reset is preset_n, asynchronous and active-low.

Function
REQ-004 cmd_ready SHALL equal !fifo_full; a command is pushed at a rising edge with cmd_valid && cmd_ready; pushes while full are ignored.
REQ-005 FSM states SHALL be IDLE, SETUP, ACCESS, RESP.
REQ-006 IDLE -> SETUP when the FIFO is non-empty, popping the head entry into the APB output registers at that edge.
REQ-007 SETUP: psel=1, penable=0, for exactly one cycle; then -> ACCESS.
REQ-008 ACCESS: psel=1, penable=1, with all other APB outputs held stable.
REQ-009 ACCESS ends at the first edge with pready=1: capture prdata (reads) or 0 (writes), capture pslverr, clear rsp_timeout, -> RESP.
REQ-010 Timeout: with TIMEOUT_CYCLES>0, a counter counts ACCESS cycles with pready=0; when it reaches TIMEOUT_CYCLES, the transfer ends with rsp_timeout=1, rsp_slverr=1, rsp_rdata=0, -> RESP. The counter clears on entering SETUP.
REQ-011 RESP: rsp_valid=1; psel, penable, pwrite, paddr, pwdata and pstrb SHALL be 0; response fields held stable until rsp_valid && rsp_ready.
REQ-012 RESP exit: -> SETUP with a pop if the FIFO is non-empty, else -> IDLE.
REQ-013 Latency: a command pushed at edge N into an empty FIFO with the FSM in IDLE SHALL give psel=1 after edge N+1 and penable=1 after edge N+2.
REQ-014 pstrb SHALL be forced to 0 for reads; pwdata SHALL be 0 for reads.
REQ-015 pwakeup=1 whenever the FIFO is non-empty or the FSM is not IDLE; otherwise 0.
REQ-016 Simultaneous push and pop in one cycle SHALL be supported: occupancy is unchanged and order is preserved. FIFO pointers wrap modulo CMD_DEPTH.
REQ-017 All APB and rsp_* outputs SHALL be registered.

Reset
REQ-018 When preset_n=0, asynchronously: FSM=IDLE, FIFO empty, timeout counter=0, every APB output=0, rsp_valid/rsp_slverr/rsp_timeout=0, rsp_rdata=0. cmd_ready=1 while preset_n is low and after its release.
REQ-019 Reset during ACCESS or RESP SHALL drop psel/penable in the same cycle and discard queued commands and the pending response.

Verification
REQ-020 Write 0x10 data 0xDEADBEEF strb 0xF, pready=1 -> SETUP 1 cycle, ACCESS 1 cycle, rsp_valid with slverr=0, rdata=0.
REQ-021 Read 0x20, pready low 3 ACCESS cycles, prdata=0x12345678 -> penable high 4 cycles, rsp_rdata=0x12345678, pstrb=0 throughout.
REQ-022 Push 5 commands with rsp_ready=1 and CMD_DEPTH=4 -> cmd_ready=0 after 4 are queued (if none popped); all issue in order, back-to-back RESP->SETUP.
REQ-023 TIMEOUT_CYCLES=16, pready stuck 0 -> abort after 16 ACCESS cycles, rsp_timeout=1, rsp_slverr=1, next command proceeds normally.
REQ-024 rsp_ready=0 for 10 cycles in RESP -> response stable, psel=0, no new SETUP until accepted.
REQ-025 preset_n low mid-ACCESS -> psel=penable=0 immediately, FIFO empty, cmd_ready=1.

Source files
------------

// File: rtl/apb_cmd_requester.sv
// APB requester fed by a small command FIFO.
// Commands are queued and issued one at a time as SETUP/ACCESS transfers.
// Each result is held in a response register until it is consumed.
// An optional ACCESS-phase timeout aborts a transfer whose completer never answers.
module apb_cmd_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  input  logic                    cmd_nse,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    pnse,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pwakeup,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int PTR_W   = $clog2(CMD_DEPTH);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_W + 3 + 1;
  localparam int TMO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               tmo_hit;

  logic [ENTRY_W-1:0] fifo_mem [CMD_DEPTH];
  logic [PTR_W:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic               fifo_empty, fifo_full, fifo_nonempty_nxt;
  logic               push, pop;

  logic                  h_write;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic [STRB_W-1:0]     h_strb;
  logic [2:0]            h_prot;
  logic                  h_nse;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cmd_ready  = !fifo_full;

  assign push = cmd_valid && !fifo_full;
  assign pop  = !fifo_empty && ((state == S_IDLE) || ((state == S_RESP) && rsp_ready));

  assign wr_ptr_nxt        = wr_ptr + (PTR_W + 1)'(push);
  assign rd_ptr_nxt        = rd_ptr + (PTR_W + 1)'(pop);
  assign fifo_nonempty_nxt = (wr_ptr_nxt != rd_ptr_nxt);

  assign {h_write, h_addr, h_wdata, h_strb, h_prot, h_nse} = fifo_mem[rd_ptr[PTR_W-1:0]];

  // Abort fires on the ACCESS cycle that would be the TIMEOUT_CYCLES-th wait state.
  assign tmo_hit = (TIMEOUT_CYCLES > 0) && !pready && (tmo_cnt == TMO_LAST);

  // Command storage; contents need no reset since the pointers define validity.
  always_ff @(posedge pclk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot, cmd_nse};
    end
  end

  // FIFO pointers; push and pop may happen on the same edge.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Transfer sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!fifo_empty) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (pready || tmo_hit) state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = fifo_empty ? S_IDLE : S_SETUP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Registered APB drive, response capture and wait-state counter.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      pnse        <= 1'b0;
      pwakeup     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      pwakeup <= fifo_nonempty_nxt || (state_nxt != S_IDLE);

      if ((state == S_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      // Head entry goes straight into the SETUP-phase outputs.
      if (pop) begin
        psel    <= 1'b1;
        penable <= 1'b0;
        pwrite  <= h_write;
        paddr   <= h_addr;
        pwdata  <= h_write ? h_wdata : '0;
        pstrb   <= h_write ? h_strb : '0;
        pprot   <= h_prot;
        pnse    <= h_nse;
        tmo_cnt <= '0;
      end

      if (state == S_SETUP) begin
        penable <= 1'b1;
      end

      if (state == S_ACCESS) begin
        if (pready || tmo_hit) begin
          // A real completion wins over a timeout landing on the same edge.
          psel        <= 1'b0;
          penable     <= 1'b0;
          pwrite      <= 1'b0;
          paddr       <= '0;
          pwdata      <= '0;
          pstrb       <= '0;
          pprot       <= '0;
          pnse        <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_rdata   <= (pready && !pwrite) ? prdata : '0;
          rsp_slverr  <= pready ? pslverr : 1'b1;
          rsp_timeout <= !pready;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_requester.sv
// Directed bench for apb_cmd_requester with default parameters.
module tb_apb_cmd_requester;

  logic        pclk;
  logic        preset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        cmd_nse;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        pnse;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pwakeup;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        err_on_108;

  int n_checks = 0;
  int n_errors = 0;

  // Completer flags an error only for the transfer to 0x108.
  assign pslverr = err_on_108 && psel && (paddr == 32'h108);

  apb_cmd_requester #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot), .cmd_nse(cmd_nse),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pprot(pprot), .pnse(pnse), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pwakeup(pwakeup),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one command for a single edge; returns on the following falling edge.
  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = 3'b010;
    cmd_nse   = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int pen, output logic seen);
    pen  = 0;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge pclk);
      if (penable) pen++;
      if (rsp_valid) seen = 1'b1;
    end
  endtask

  logic [31:0] ba [5];
  logic        bw [5];
  logic [31:0] set_addr [5];
  int          set_cyc [5];
  logic        rsp_err [5];
  logic [31:0] rsp_dat [5];

  initial begin
    int   pen;
    logic seen;
    logic strb_bad;
    logic took;
    int   n_set, n_rsp;

    ba[0] = 32'h100; bw[0] = 1'b1;
    ba[1] = 32'h104; bw[1] = 1'b0;
    ba[2] = 32'h108; bw[2] = 1'b1;
    ba[3] = 32'h10C; bw[3] = 1'b0;
    ba[4] = 32'h110; bw[4] = 1'b0;

    preset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; cmd_nse = 1'b0;
    rsp_ready = 1'b0; pready = 1'b1; prdata = '0; err_on_108 = 1'b0;

    // Reset state
    repeat (2) @(negedge pclk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_pwakeup", pwakeup, 0);
    preset_n = 1'b1;
    @(negedge pclk);

    // Single write with zero wait states
    push(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    check("wr_idle_psel", psel, 0);
    check("wr_wakeup", pwakeup, 1);
    @(negedge pclk);
    check("wr_setup_psel", psel, 1);
    check("wr_setup_penable", penable, 0);
    check("wr_setup_paddr", paddr, 32'h10);
    check("wr_setup_pwrite", pwrite, 1);
    check("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
    check("wr_setup_pstrb", pstrb, 4'hF);
    check("wr_setup_pprot", pprot, 3'b010);
    @(negedge pclk);
    check("wr_access_penable", penable, 1);
    check("wr_access_paddr", paddr, 32'h10);
    @(negedge pclk);
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_slverr", rsp_slverr, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_rsp_timeout", rsp_timeout, 0);
    check("wr_rsp_psel", psel, 0);
    check("wr_rsp_paddr", paddr, 0);
    rsp_ready = 1'b1;
    @(negedge pclk);
    check("wr_done_rsp_valid", rsp_valid, 0);
    check("wr_done_wakeup", pwakeup, 0);

    // Read with three wait states
    pready = 1'b0;
    prdata = 32'h12345678;
    push(1'b0, 32'h20, 32'hFFFFFFFF, 4'hF);
    @(negedge pclk);
    check("rd_setup_psel", psel, 1);
    check("rd_setup_pwrite", pwrite, 0);
    check("rd_setup_pstrb", pstrb, 0);
    check("rd_setup_pwdata", pwdata, 0);
    check("rd_setup_paddr", paddr, 32'h20);
    pen = 0; strb_bad = 1'b0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge pclk);
      if (penable) begin
        pen++;
        if (pstrb != 4'h0) strb_bad = 1'b1;
        if (pen == 4) pready = 1'b1;
      end
      if (rsp_valid) seen = 1'b1;
    end
    check("rd_rsp_seen", seen, 1);
    check("rd_penable_cycles", pen, 4);
    check("rd_pstrb_zero", strb_bad, 0);
    check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    check("rd_rsp_slverr", rsp_slverr, 0);
    @(negedge pclk);

    // Held response while four commands fill the FIFO and a fifth waits
    rsp_ready = 1'b0;
    pready = 1'b1;
    prdata = 32'h0BADF00D;
    push(1'b0, 32'h30, 32'h0, 4'h0);
    wait_rsp(pen, seen);
    check("stall_rsp_seen", seen, 1);
    prdata = 32'h5A5A0000;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) begin
        cmd_valid = 1'b1; cmd_write = bw[i]; cmd_addr = ba[i];
        cmd_wdata = 32'hC0DE0000 + i; cmd_strb = 4'hF; cmd_prot = 3'b000; cmd_nse = 1'b0;
      end
      @(negedge pclk);
      if (i < 4) cmd_valid = 1'b0;
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_rdata", rsp_rdata, 32'h0BADF00D);
      check("stall_psel", psel, 0);
      if (i == 0) check("stall_ready_1", cmd_ready, 1);
      if (i == 3) check("stall_full", cmd_ready, 0);
    end

    // Release: five back-to-back transfers in order
    rsp_ready = 1'b1;
    err_on_108 = 1'b1;
    n_set = 0; n_rsp = 0;
    for (int c = 0; c < 60 && n_rsp < 5; c++) begin
      took = cmd_valid && cmd_ready;
      @(negedge pclk);
      if (took) cmd_valid = 1'b0;
      if (psel && !penable) begin
        if (n_set < 5) begin set_addr[n_set] = paddr; set_cyc[n_set] = c; end
        n_set++;
      end
      if (rsp_valid) begin
        if (n_rsp < 5) begin rsp_err[n_rsp] = rsp_slverr; rsp_dat[n_rsp] = rsp_rdata; end
        n_rsp++;
      end
    end
    err_on_108 = 1'b0;
    check("burst_setups", n_set, 5);
    check("burst_rsps", n_rsp, 5);
    for (int k = 0; k < 5; k++) begin
      if (k < n_set) begin
        check("burst_addr", set_addr[k], ba[k]);
        check("burst_setup_cycle", set_cyc[k], 3 * k);
      end
      if (k < n_rsp) begin
        check("burst_slverr", rsp_err[k], (k == 2) ? 1 : 0);
        check("burst_rdata", rsp_dat[k], bw[k] ? 32'h0 : 32'h5A5A0000);
      end
    end
    @(negedge pclk);

    // Timeout on a stuck completer, then a normal transfer
    pready = 1'b0;
    prdata = 32'hAAAA5555;
    push(1'b0, 32'h200, 32'h0, 4'h0);
    wait_rsp(pen, seen);
    check("tmo_rsp_seen", seen, 1);
    check("tmo_penable_cycles", pen, 16);
    check("tmo_rsp_timeout", rsp_timeout, 1);
    check("tmo_rsp_slverr", rsp_slverr, 1);
    check("tmo_rsp_rdata", rsp_rdata, 0);
    pready = 1'b1;
    @(negedge pclk);
    push(1'b1, 32'h204, 32'h13572468, 4'h3);
    wait_rsp(pen, seen);
    check("post_tmo_seen", seen, 1);
    check("post_tmo_penable_cycles", pen, 1);
    check("post_tmo_timeout", rsp_timeout, 0);
    check("post_tmo_slverr", rsp_slverr, 0);
    @(negedge pclk);

    // Reset in the middle of ACCESS with a command still queued
    pready = 1'b0;
    push(1'b0, 32'h300, 32'h0, 4'h0);
    push(1'b1, 32'h304, 32'h1, 4'hF);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (penable) seen = 1'b1;
      else @(negedge pclk);
    end
    check("mid_access_reached", seen, 1);
    #2 preset_n = 1'b0;
    #1;
    check("arst_psel", psel, 0);
    check("arst_penable", penable, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_wakeup", pwakeup, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    @(negedge pclk);
    preset_n = 1'b1;
    pready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      if (psel || rsp_valid) seen = 1'b1;
    end
    check("arst_queue_flushed", seen, 0);
    check("arst_after_wakeup", pwakeup, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
